// File: rtl/fir_pkg.sv
// Shared types, default low-pass coefficients and the accumulator width helper
// for the symmetric serial FIR.
package fir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DONE} fir_state_t;

    localparam int unsigned LP_TAPS  = 31;
    localparam int unsigned LP_NHALF = (LP_TAPS + 1) / 2;

    // c[0] is the outermost pair, c[LP_NHALF-1] the centre tap.
    localparam logic [0:LP_NHALF-1][7:0] LP_COEFS = '{
        8'd3,  8'd4,  8'd6,  8'd8,  8'd12, 8'd17, 8'd23, 8'd29,
        8'd36, 8'd43, 8'd50, 8'd56, 8'd61, 8'd65, 8'd67, 8'd68
    };

    function automatic int unsigned fir_acc_w(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned nhalf);
        return data_w + coef_w + 1 + $clog2(nhalf);
    endfunction

endpackage

// File: rtl/fir_sym_serial_if.sv
// Sample-in / filtered-out handshake bundle for fir_sym_serial.
interface fir_sym_serial_if #(
    parameter int unsigned DATA_W = 10
) ();

    logic              clear;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_in;
    logic              in_ready;
    logic              filt_valid;
    logic [DATA_W-1:0] filt_out;
    logic              busy;

    modport master (
        output clear, sample_valid, sample_in,
        input  in_ready, filt_valid, filt_out, busy
    );

    modport slave (
        input  clear, sample_valid, sample_in,
        output in_ready, filt_valid, filt_out, busy
    );

endinterface

// File: rtl/fir_pair_mac.sv
// Folded-pair pre-add, coefficient multiply and accumulate for one tap index per cycle.
module fir_pair_mac #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned TAPS   = 31,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned NHALF  = (TAPS + 1) / 2,
    parameter int unsigned ACC_W  = 23,
    parameter logic [0:NHALF-1][COEF_W-1:0] COEFS = '0,
    localparam int unsigned IDX_W = $clog2(NHALF),
    localparam int unsigned TAP_W = $clog2(TAPS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         acc_clr,
    input  logic                         acc_en,
    input  logic [IDX_W-1:0]             idx,
    input  logic [0:TAPS-1][DATA_W-1:0]  dline,
    output logic [ACC_W-1:0]             acc
);

    localparam int unsigned SUM_W  = DATA_W + 1;
    localparam int unsigned PROD_W = DATA_W + 1 + COEF_W;

    logic [TAP_W-1:0]  lo_idx;
    logic [TAP_W-1:0]  hi_idx;
    logic              centre;
    logic [SUM_W-1:0]  pair_sum;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_q;

    always_comb begin
        lo_idx   = TAP_W'(idx);
        hi_idx   = TAP_W'(TAPS - 1) - lo_idx;
        centre   = (idx == IDX_W'(NHALF - 1));
        pair_sum = {1'b0, dline[lo_idx]};
        // The centre tap has no mirror partner, so it is counted once.
        if (!centre) begin
            pair_sum = pair_sum + {1'b0, dline[hi_idx]};
        end
        prod = PROD_W'(pair_sum) * PROD_W'(COEFS[idx]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (acc_en) begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_sym_serial.sv
// Time-multiplexed symmetric FIR: delay line, control FSM, round and saturate.
// One folded coefficient pair is accumulated per clock by fir_pair_mac.
module fir_sym_serial
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned TAPS   = 31,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned SHIFT  = 10,
    parameter logic [0:(TAPS+1)/2-1][COEF_W-1:0] COEFS = LP_COEFS
) (
    input logic             clk,
    input logic             reset,
    fir_sym_serial_if.slave bus
);

    localparam int unsigned NHALF = (TAPS + 1) / 2;
    localparam int unsigned IDX_W = $clog2(NHALF);
    localparam int unsigned ACC_W = fir_acc_w(DATA_W, COEF_W, NHALF);
    localparam int unsigned RND_W = ACC_W + 1;

    if ((TAPS % 2) == 0 || TAPS < 3) begin : g_bad_taps
        $error("fir_sym_serial: TAPS must be odd and at least 3");
    end

    fir_state_t                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [0:TAPS-1][DATA_W-1:0] dline_q, dline_d;
    logic [DATA_W-1:0]          filt_out_q, filt_out_d;
    logic                       filt_valid_q, filt_valid_d;
    logic                       acc_clr;
    logic                       acc_en;
    logic [ACC_W-1:0]           acc;
    logic [RND_W-1:0]           rounded;
    logic [RND_W-1:0]           scaled;
    logic [DATA_W-1:0]          result;

    fir_pair_mac #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .NHALF  (NHALF),
        .ACC_W  (ACC_W),
        .COEFS  (COEFS)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .acc_clr (acc_clr),
        .acc_en  (acc_en),
        .idx     (idx_q),
        .dline   (dline_q),
        .acc     (acc)
    );

    // Round half up, then clamp to the unsigned output range.
    always_comb begin
        rounded = RND_W'(acc) + (RND_W'(1) << (SHIFT - 1));
        scaled  = rounded >> SHIFT;
        if (scaled > RND_W'({DATA_W{1'b1}})) begin
            result = '1;
        end else begin
            result = DATA_W'(scaled);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dline_d      = dline_q;
        filt_out_d   = filt_out_q;
        filt_valid_d = 1'b0;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            idx_d   = '0;
            dline_d = '0;
            acc_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.sample_valid) begin
                        dline_d = {bus.sample_in, dline_q[0:TAPS-2]};
                        idx_d   = '0;
                        acc_clr = 1'b1;
                        state_d = MAC;
                    end
                end
                MAC: begin
                    acc_en = 1'b1;
                    if (idx_q == IDX_W'(NHALF - 1)) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    filt_out_d   = result;
                    filt_valid_d = 1'b1;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dline_q      <= '0;
            filt_out_q   <= '0;
            filt_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dline_q      <= dline_d;
            filt_out_q   <= filt_out_d;
            filt_valid_q <= filt_valid_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.filt_valid = filt_valid_q;
    assign bus.filt_out   = filt_out_q;

endmodule

// File: tb/tb_fir_sym_serial.sv
// Directed and random checks of fir_sym_serial against a direct-form convolution model.
module tb_fir_sym_serial;

    localparam int DATA_W = 10;
    localparam int TAPS   = 31;
    localparam int NHALF  = 16;
    localparam int SHIFT  = 10;
    localparam int LAT    = NHALF + 1;
    localparam int PERIOD = NHALF + 2;
    localparam int MAXV   = (1 << DATA_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    int coef_tb [NHALF] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};
    int hist [TAPS];

    fir_sym_serial_if #(.DATA_W(DATA_W)) bus ();

    fir_sym_serial #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .COEF_W (8),
        .SHIFT  (SHIFT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_clear();
        for (int t = 0; t < TAPS; t++) hist[t] = 0;
    endfunction

    function automatic void ref_push(input int s);
        for (int t = TAPS - 1; t > 0; t--) hist[t] = hist[t-1];
        hist[0] = s;
    endfunction

    // Full 31-tap convolution with the mirrored coefficient vector.
    function automatic int ref_out();
        longint acc = 0;
        for (int t = 0; t < TAPS; t++) begin
            acc += longint'(coef_tb[(t < NHALF) ? t : TAPS - 1 - t]) * longint'(hist[t]);
        end
        acc = (acc + (1 << (SHIFT - 1))) / (1 << SHIFT);
        if (acc > MAXV) acc = MAXV;
        return int'(acc);
    endfunction

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        ref_clear();
    endtask

    task automatic push(input int s, input string tag, output int out);
        int waitc;
        int lat;
        waitc = 0;
        while (bus.in_ready !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, "_ready"}, bus.in_ready, 1);
        bus.sample_valid = 1'b1;
        bus.sample_in    = DATA_W'(s);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        ref_push(s);
        lat = 0;
        while (bus.filt_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_out"}, bus.filt_out, ref_out());
        out = int'(bus.filt_out);
    endtask

    initial begin
        int o;
        int nv;
        int last_acc;
        int n_acc;
        int last_exp;
        int exp_q[$];

        bus.clear        = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        ref_clear();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out", bus.filt_out, 0);
        chk("rst_valid", bus.filt_valid, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", bus.in_ready, 1);
        chk("idle_busy", bus.busy, 0);

        // Impulse response
        pulse_clear();
        for (int n = 1; n <= 34; n++) begin
            push((n == 1) ? 1000 : 0, "impulse", o);
            if (n == 1)  chk("imp_first", o, 3);
            if (n == 16) chk("imp_centre", o, 66);
            if (n == 17) chk("imp_mirror", o, 65);
            if (n == 32) chk("imp_tail", o, 0);
        end
        @(negedge clk);
        chk("valid_one_cycle", bus.filt_valid, 0);

        // Step settles to the DC gain
        pulse_clear();
        for (int n = 0; n < TAPS; n++) push(100, "step", o);
        chk("step_final", o, 100);

        // Saturation at full-scale DC
        for (int n = 0; n < TAPS; n++) push(MAXV, "sat", o);
        chk("sat_final", o, MAXV);

        // Random samples
        pulse_clear();
        for (int n = 0; n < 40; n++) push(int'($urandom_range(0, MAXV)), "rand", o);

        // sample_valid held high with changing data: one accept per PERIOD cycles
        pulse_clear();
        last_acc = -1;
        n_acc    = 0;
        last_exp = 0;
        bus.sample_valid = 1'b1;
        for (int c = 0; c < PERIOD * 6 + 20; c++) begin
            if (bus.filt_valid === 1'b1) begin
                chk("stream_out", bus.filt_out, (exp_q.size() > 0) ? exp_q.pop_front() : -1);
            end
            bus.sample_in = DATA_W'($urandom_range(0, MAXV));
            if (bus.in_ready === 1'b1) begin
                if (last_acc >= 0) chk("stream_period", c - last_acc, PERIOD);
                last_acc = c;
                n_acc++;
                ref_push(int'(bus.sample_in));
                last_exp = ref_out();
                exp_q.push_back(last_exp);
            end
            @(negedge clk);
        end
        bus.sample_valid = 1'b0;
        chk("stream_count", n_acc, 8);
        nv = 0;
        while (bus.filt_valid !== 1'b1 && nv < 40) begin
            @(negedge clk);
            nv++;
        end
        chk("stream_drain", bus.filt_out, (exp_q.size() > 0) ? exp_q.pop_front() : -1);
        @(negedge clk);

        // clear at MAC idx=5 together with a new sample
        pulse_clear();
        bus.sample_valid = 1'b1;
        bus.sample_in    = DATA_W'(500);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        bus.clear        = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_in    = DATA_W'(777);
        @(negedge clk);
        bus.clear        = 1'b0;
        bus.sample_valid = 1'b0;
        ref_clear();
        chk("clr_busy", bus.busy, 0);
        chk("clr_ready", bus.in_ready, 1);
        chk("clr_hold_out", bus.filt_out, last_exp);
        nv = 0;
        repeat (25) begin
            if (bus.filt_valid === 1'b1) nv++;
            @(negedge clk);
        end
        chk("clr_no_valid", nv, 0);

        // clear wins over a same-cycle accept in IDLE
        bus.clear        = 1'b1;
        bus.sample_valid = 1'b1;
        bus.sample_in    = DATA_W'(900);
        @(negedge clk);
        bus.clear        = 1'b0;
        bus.sample_valid = 1'b0;
        chk("clr_prio_busy", bus.busy, 0);
        push(1000, "after_clr", o);
        chk("after_clr_first", o, 3);

        // Reset during MAC aborts without output
        bus.sample_valid = 1'b1;
        bus.sample_in    = DATA_W'(800);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_out", bus.filt_out, 0);
        chk("rst_mid_busy", bus.busy, 0);
        reset = 1'b0;
        ref_clear();
        nv = 0;
        repeat (25) begin
            if (bus.filt_valid === 1'b1) nv++;
            @(negedge clk);
        end
        chk("rst_no_valid", nv, 0);
        push(1000, "after_rst", o);
        chk("after_rst_first", o, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
